// File: rtl/spi_usb_responder.sv
// SPI mode-0 responder speaking a MAX3421E-style register protocol: 32x8 register
// file, receive FIFO behind address 1, HIRQ at address 25 and its enable mask at 26.
module spi_usb_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oe,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic [7:0] irq_set,
  output logic       INT_n,
  input  logic [4:0] loc_addr,
  output logic [7:0] loc_rdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [4:0] ADDR_FIFO = 5'd1;
  localparam logic [4:0] ADDR_HIRQ = 5'd25;
  localparam logic [4:0] ADDR_HIEN = 5'd26;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_sreg_q, rx_sreg_d, tx_sreg_q, tx_sreg_d;
  logic [4:0]             addr_q, addr_d;
  logic                   is_wr_q, is_wr_d;
  logic                   miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                   int_n_q, int_n_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [4:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             hirq_q, hirq_d;
  logic [7:0]             regs_q [32];
  logic [7:0]             regs_d [32];
  logic [7:0]             fifo_q [FIFO_DEPTH];
  logic [7:0]             fifo_d [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic       fifo_empty, fifo_full, push_acc, pop_req, pop_acc;
  logic [7:0] fifo_head, hirq_live, rx_byte, rd_data, hirq_clr;
  logic [4:0] rd_addr;

  always_comb begin
    sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    ss_s       = ss_sync_q[SYNC_STAGES-1];
    mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise  = sclk_s & ~sclk_prev_q;
    sclk_fall  = ~sclk_s & sclk_prev_q;
    ss_rise    = ss_s & ~ss_prev_q;
    ss_fall    = ~ss_s & ss_prev_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    fifo_head  = fifo_q[rd_ptr_q[AW-1:0]];
    hirq_live  = {hirq_q[7:3], ~fifo_empty, hirq_q[1:0]};
    rx_byte    = {rx_sreg_q[6:0], mosi_s};
    // During the command byte the address being decoded is the one still in the shifter.
    rd_addr    = (state_q == CMD) ? rx_byte[7:3] : addr_q;
    if (rd_addr == ADDR_FIFO)      rd_data = fifo_empty ? 8'h00 : fifo_head;
    else if (rd_addr == ADDR_HIRQ) rd_data = hirq_live;
    else                           rd_data = regs_q[rd_addr];
  end

  always_comb begin
    state_d     = state_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    bit_cnt_d   = bit_cnt_q;
    rx_sreg_d   = rx_sreg_q;
    tx_sreg_d   = tx_sreg_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pop_req     = 1'b0;
    hirq_clr    = 8'h00;

    if (ss_rise) begin
      state_d   = IDLE;
      miso_oe_d = 1'b0;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (ss_fall) begin
      state_d   = CMD;
      miso_oe_d = 1'b1;
      miso_d    = hirq_live[7];
      tx_sreg_d = {hirq_live[6:0], 1'b0};
      bit_cnt_d = 3'd0;
    end else if (state_q != IDLE) begin
      if (sclk_rise) begin
        rx_sreg_d = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (state_q == CMD) begin
            state_d   = DATA;
            addr_d    = rx_byte[7:3];
            is_wr_d   = rx_byte[1];
            tx_sreg_d = rx_byte[1] ? 8'h00 : rd_data;
            pop_req   = ~rx_byte[1] && (rx_byte[7:3] == ADDR_FIFO);
          end else if (is_wr_q) begin
            if (addr_q != ADDR_FIFO) begin
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = rx_byte;
              if (addr_q == ADDR_HIRQ) hirq_clr = rx_byte;
              else                     regs_d[addr_q] = rx_byte;
            end
          end else begin
            tx_sreg_d = rd_data;
            pop_req   = (addr_q == ADDR_FIFO);
          end
        end
      end else if (sclk_fall) begin
        miso_d    = tx_sreg_q[7];
        tx_sreg_d = {tx_sreg_q[6:0], 1'b0};
      end
    end

    pop_acc  = pop_req & ~fifo_empty;
    push_acc = push_valid & ~fifo_full;
    if (push_acc) begin
      fifo_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;

    // Set has priority over an SPI write-1 clear; bit 2 is never stored.
    hirq_d  = ((hirq_q & ~hirq_clr) | irq_set) & 8'hFB;
    int_n_d = ~|(hirq_live & regs_q[ADDR_HIEN]);
  end

  // SS_n synchroniser resets low so a select held low through reset is not taken as a fall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sreg_q   <= 8'h00;
      tx_sreg_q   <= 8'h00;
      addr_q      <= 5'd0;
      is_wr_q     <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      int_n_q     <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      hirq_q      <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sreg_q   <= rx_sreg_d;
      tx_sreg_q   <= tx_sreg_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      int_n_q     <= int_n_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      hirq_q      <= hirq_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      regs_q      <= regs_d;
      fifo_q      <= fifo_d;
    end
  end

  always_comb begin
    if (loc_addr == ADDR_FIFO)      loc_rdata = fifo_empty ? 8'h00 : fifo_head;
    else if (loc_addr == ADDR_HIRQ) loc_rdata = hirq_live;
    else                            loc_rdata = regs_q[loc_addr];
  end

  assign MISO       = miso_q;
  assign MISO_oe    = miso_oe_q;
  assign push_ready = ~fifo_full;
  assign INT_n      = int_n_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_spi_usb_responder.sv
// Directed bench for spi_usb_responder: an SPI master driver plus a transaction-level
// model of the register map, FIFO and HIRQ that predicts every response byte.
module tb_spi_usb_responder;
  localparam int DEPTH = 8;
  localparam int HALF  = 5;

  logic       Clk = 1'b0;
  logic       Reset_n, SCLK, SS_n, MOSI, push_valid;
  logic [7:0] push_data, irq_set;
  logic [4:0] loc_addr;
  logic       MISO, MISO_oe, push_ready, INT_n, wr_strobe;
  logic [7:0] loc_rdata, wr_data;
  logic [4:0] wr_addr;

  spi_usb_responder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .irq_set(irq_set), .INT_n(INT_n), .loc_addr(loc_addr),
    .loc_rdata(loc_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #10 Clk = ~Clk;

  int          n_compared = 0;
  int          n_failed = 0;
  int          strobe_count = 0;
  bit          chk_en = 1'b0;
  int          pulse_byte = -1;
  logic [7:0]  pulse_val = 8'h00;
  logic [7:0]  m_regs [32];
  logic [7:0]  m_fifo [$];
  logic [7:0]  m_hirq;
  logic [12:0] exp_writes [$];
  logic [7:0]  tx_bytes [16];
  logic [7:0]  rx_bytes [16];
  logic [7:0]  exp_rx [16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] m_hirq_live();
    logic ne;
    ne = (m_fifo.size() != 0);
    return {m_hirq[7:3], ne, m_hirq[1:0]};
  endfunction

  function automatic logic [7:0] m_peek(input logic [4:0] a);
    if (a == 5'd1) return (m_fifo.size() == 0) ? 8'h00 : m_fifo[0];
    if (a == 5'd25) return m_hirq_live();
    return m_regs[a];
  endfunction

  function automatic logic [7:0] m_load(input logic [4:0] a);
    logic [7:0] v;
    v = m_peek(a);
    if (a == 5'd1 && m_fifo.size() != 0) void'(m_fifo.pop_front());
    return v;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [7:0] d, input int k);
    if (a == 5'd1) return;
    exp_writes.push_back({a, d});
    if (a == 5'd25) begin
      m_hirq = m_hirq & ~d;
      if (pulse_byte == k) m_hirq = m_hirq | pulse_val;
      m_hirq = m_hirq & 8'hFB;
    end else begin
      m_regs[a] = d;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_fifo.delete();
    exp_writes.delete();
    m_hirq = 8'h00;
  endtask

  // Predicts the bytes the master samples and applies every completed byte's effect.
  task automatic model_txn(input int n_bytes, input int abort_bits);
    int n_full;
    logic [4:0] a;
    logic w;
    n_full = (abort_bits < 0) ? n_bytes : n_bytes - 1;
    for (int j = 0; j < 16; j++) exp_rx[j] = 8'h00;
    exp_rx[0] = m_hirq_live();
    if (n_full >= 1) begin
      a = tx_bytes[0][7:3];
      w = tx_bytes[0][1];
      if (!w) exp_rx[1] = m_load(a);
      for (int k = 1; k < n_full; k++) begin
        if (w) m_write(a, tx_bytes[k], k);
        else if (k + 1 < 16) exp_rx[k + 1] = m_load(a);
      end
    end
  endtask

  task automatic applyStimulus(input int n_bytes, input int abort_bits);
    chk_en = 1'b0;
    @(negedge Clk);
    SS_n = 1'b0;
    repeat (6) @(negedge Clk);
    for (int b = 0; b < n_bytes; b++) begin
      rx_bytes[b] = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        if (abort_bits >= 0 && b == n_bytes - 1 && (7 - i) >= abort_bits) continue;
        MOSI = tx_bytes[b][i];
        repeat (HALF) @(negedge Clk);
        rx_bytes[b][i] = MISO;
        SCLK = 1'b1;
        for (int j = 0; j < HALF; j++) begin
          @(negedge Clk);
          if (b == pulse_byte && i == 0 && j == 1) irq_set = pulse_val;
          if (b == pulse_byte && i == 0 && j == 2) irq_set = 8'h00;
        end
        SCLK = 1'b0;
      end
    end
    repeat (HALF) @(negedge Clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge Clk);
    chk_en = 1'b1;
  endtask

  task automatic do_txn(input int n_bytes, input int abort_bits);
    int n_full;
    n_full = (abort_bits < 0) ? n_bytes : n_bytes - 1;
    model_txn(n_bytes, abort_bits);
    applyStimulus(n_bytes, abort_bits);
    for (int j = 0; j < n_full; j++)
      checkOutput($sformatf("rx byte %0d", j), 32'(rx_bytes[j]), 32'(exp_rx[j]));
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] d, input int abort_bits);
    tx_bytes[0] = cmd;
    tx_bytes[1] = d;
    do_txn(2, abort_bits);
  endtask

  task automatic read_n(input logic [7:0] cmd, input int n);
    tx_bytes[0] = cmd;
    for (int j = 1; j <= n; j++) tx_bytes[j] = 8'h00;
    do_txn(n + 1, -1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    chk_en = 1'b0;
    @(negedge Clk);
    push_valid = 1'b1;
    push_data  = d;
    @(negedge Clk);
    push_valid = 1'b0;
    if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    chk_en = 1'b0;
    @(negedge Clk);
    irq_set = v;
    @(negedge Clk);
    irq_set = 8'h00;
    m_hirq = (m_hirq | v) & 8'hFB;
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
  endtask

  task automatic set_loc(input logic [4:0] a);
    chk_en = 1'b0;
    @(negedge Clk);
    loc_addr = a;
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
  endtask

  task automatic check_reset_values();
    checkOutput("reset MISO", 32'(MISO), 32'(1'b0));
    checkOutput("reset MISO_oe", 32'(MISO_oe), 32'(1'b0));
    checkOutput("reset INT_n", 32'(INT_n), 32'(1'b1));
    checkOutput("reset wr_strobe", 32'(wr_strobe), 32'(1'b0));
    checkOutput("reset wr_addr", 32'(wr_addr), 32'(5'd0));
    checkOutput("reset wr_data", 32'(wr_data), 32'(8'h00));
    checkOutput("reset push_ready", 32'(push_ready), 32'(1'b1));
    checkOutput("reset loc_rdata", 32'(loc_rdata), 32'(8'h00));
  endtask

  // Idle-time outputs against the model, plus every write strobe against the expected list.
  always @(negedge Clk) begin
    logic [12:0] w;
    if (chk_en && Reset_n) begin
      checkOutput("push_ready", 32'(push_ready), 32'(m_fifo.size() < DEPTH));
      checkOutput("INT_n", 32'(INT_n), 32'(~|(m_hirq_live() & m_regs[26])));
      checkOutput("MISO_oe idle", 32'(MISO_oe), 32'(1'b0));
      checkOutput("MISO idle", 32'(MISO), 32'(1'b0));
      checkOutput("loc_rdata", 32'(loc_rdata), 32'(m_peek(loc_addr)));
    end
    if (Reset_n && wr_strobe === 1'b1) begin
      strobe_count++;
      if (exp_writes.size() == 0) begin
        checkOutput("unexpected wr_strobe", 32'({wr_addr, wr_data}), 32'h1FFFF);
      end else begin
        w = exp_writes.pop_front();
        checkOutput("wr_strobe addr/data", 32'({wr_addr, wr_data}), 32'(w));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    Reset_n = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    push_valid = 1'b0; push_data = 8'h00; irq_set = 8'h00; loc_addr = 5'd5;
    m_reset();
    #3 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check_reset_values();
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    chk_en = 1'b1;

    $display("[TB] write then read register 5");
    write_reg(8'h2A, 8'hA5, -1);
    checkOutput("strobe count after write", 32'(strobe_count), 32'd1);
    read_n(8'h28, 1);
    checkOutput("read reg5 literal", 32'(rx_bytes[1]), 32'h0000_00A5);
    checkOutput("loc_rdata reg5 literal", 32'(loc_rdata), 32'h0000_00A5);

    $display("[TB] FIFO drain");
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    read_n(8'h08, 4);
    checkOutput("drain status literal", 32'(rx_bytes[0]), 32'h04);
    checkOutput("drain byte1 literal", 32'(rx_bytes[1]), 32'h11);
    checkOutput("drain byte3 literal", 32'(rx_bytes[3]), 32'h33);
    checkOutput("drain byte4 literal", 32'(rx_bytes[4]), 32'h00);
    set_loc(5'd25);
    checkOutput("HIRQ after drain literal", 32'(loc_rdata), 32'h00);

    $display("[TB] FIFO full");
    for (int i = 0; i < 8; i++) push_byte(8'h41 + 8'(i));
    checkOutput("push_ready full literal", 32'(push_ready), 32'd0);
    push_byte(8'h49);
    read_n(8'h08, 9);
    checkOutput("full first literal", 32'(rx_bytes[1]), 32'h41);
    checkOutput("full eighth literal", 32'(rx_bytes[8]), 32'h48);
    checkOutput("full ninth lost literal", 32'(rx_bytes[9]), 32'h00);

    $display("[TB] interrupt");
    write_reg(8'hD2, 8'h01, -1);
    pulse_irq(8'h01);
    checkOutput("INT_n asserted literal", 32'(INT_n), 32'd0);
    read_n(8'h28, 1);
    checkOutput("status 0x01 literal", 32'(rx_bytes[0]), 32'h01);
    write_reg(8'hCA, 8'h01, -1);
    checkOutput("INT_n cleared literal", 32'(INT_n), 32'd1);
    pulse_byte = 1;
    pulse_val  = 8'h01;
    write_reg(8'hCA, 8'h01, -1);
    pulse_byte = -1;
    checkOutput("set wins literal", 32'(loc_rdata), 32'h01);
    checkOutput("INT_n after set-wins literal", 32'(INT_n), 32'd0);
    pulse_irq(8'h84);
    read_n(8'h28, 1);
    checkOutput("status 0x81 literal", 32'(rx_bytes[0]), 32'h81);

    $display("[TB] abort mid data byte");
    set_loc(5'd7);
    write_reg(8'h3A, 8'h3C, -1);
    sc = strobe_count;
    write_reg(8'h3A, 8'hFF, 4);
    checkOutput("abort reg7 literal", 32'(loc_rdata), 32'h3C);
    checkOutput("abort MISO_oe literal", 32'(MISO_oe), 32'd0);
    checkOutput("abort no strobe", 32'(strobe_count), 32'(sc));

    $display("[TB] reset mid read");
    set_loc(5'd5);
    push_byte(8'h5A);
    chk_en = 1'b0;
    @(negedge Clk);
    SS_n = 1'b0;
    repeat (6) @(negedge Clk);
    for (int i = 0; i < 12; i++) begin
      MOSI = (i == 4);
      repeat (HALF) @(negedge Clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge Clk);
      SCLK = 1'b0;
    end
    checkOutput("MISO_oe mid read literal", 32'(MISO_oe), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_reset_values();
    m_reset();
    repeat (2) @(negedge Clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    chk_en = 1'b1;
    read_n(8'h28, 1);
    checkOutput("reg5 after reset literal", 32'(rx_bytes[1]), 32'h00);

    chk_en = 1'b0;
    checkOutput("pending writes", 32'(exp_writes.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/spi_usb_responder.md
Name: spi_usb_responder

Overview:
- SPI mode-0 slave (responder) that emulates the MAX3421E-style register protocol spoken by the SoC's SPI master (spi0).
- Used for loopback bring-up of the USB keyboard path without the shield, and as a bench model for firmware register sequences.
- Contains a 32x8 register file, a receive FIFO at address 1, an interrupt register at address 25 and an enable register at address 26.
- All SPI pins are oversampled in the system clock domain.

Parameters:
- FIFO_DEPTH, 8: receive FIFO entries; must be a power of 2.
- SYNC_STAGES, 2: synchroniser flops on SCLK, SS_n and MOSI.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous, active-low reset.
- SCLK  in  1  SPI clock from master; idle low.
- SS_n  in  1  SPI slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_oe  out  1  high while selected; the top level tri-states MISO when low.
- push_valid  in  1  local request to push a byte into the receive FIFO.
- push_data  in  8  byte to push.
- push_ready  out  1  FIFO not full.
- irq_set  in  8  per-bit one-cycle set pulses for register 25.
- INT_n  out  1  active-low interrupt.
- loc_addr  in  5  local combinational read address.
- loc_rdata  out  8  register file value at loc_addr.
- wr_strobe  out  1  one-cycle pulse on each completed SPI register write.
- wr_addr  out  5  address of that write.
- wr_data  out  8  data of that write.

Behaviour:
- Reset values: all registers 0, FIFO empty, MISO=0, MISO_oe=0, INT_n=1, wr_strobe=0, wr_addr=0, wr_data=0, push_ready=1.
- Synchronisation: inputs pass through SYNC_STAGES flops; edges are detected on the synchronised signals. Requires Clk ≥ 8×SCLK.
- Output latency: MISO and MISO_oe change SYNC_STAGES+1 Clk cycles after the causing pin edge.
- Transaction structure:
  - Starts at synced SS_n fall.
  - Byte 0 is the command: cmd[7:3] = address, cmd[1] = 1 for write / 0 for read, cmd[0] and cmd[2] ignored.
  - All following bytes access the same address; there is no auto-increment.
- Rising SCLK: shift MOSI into rx_sreg, MSB first. The 8th rising edge of a byte is "byte complete".
- Falling SCLK: MISO <= tx_sreg[7], then tx_sreg shifts left.
- At SS_n fall:
  - MISO_oe <= 1.
  - MISO <= HIRQ[7].
  - tx_sreg <= {HIRQ[6:0],0}.
  - The status byte is HIRQ, captured at that instant.
- At command byte complete:
  - Latch address and direction.
  - For a read, tx_sreg <= data(addr); for a write, tx_sreg <= 0x00.
- At data byte complete:
  - Write: register[addr] <= rx byte and pulse wr_strobe. Exceptions below for addresses 1 and 25.
  - Read: tx_sreg <= data(addr), evaluated again for the next byte.
- data(addr) rules:
  - addr 1: FIFO head, with pop on load. If the FIFO is empty, return 0x00 and do not pop.
  - addr 25: live HIRQ.
  - Otherwise: register contents.
- Address 1 on SPI write: data ignored, no strobe.
- Address 25 (HIRQ):
  - Bit 2 is read-only and equals FIFO-not-empty.
  - The other bits are set by irq_set and cleared by SPI write-1.
  - If set and clear hit the same bit in the same cycle, set wins.
- INT_n = ~|(HIRQ & reg26), registered.
- FIFO:
  - push_ready = ~full.
  - A push when full is dropped.
  - Push and pop in the same cycle leave the count unchanged; the pop returns the old head.
- SS_n rise mid-byte:
  - Abort; discard the partial byte; no write, no pop.
  - MISO_oe <= 0, MISO <= 0.
  - The byte counter returns to the command state.
- States: IDLE → CMD (SS_n fall) → DATA (command complete) → DATA ... ; any state → IDLE on SS_n rise.
- SCLK edges while SS_n is high are ignored.
- Reset_n low mid-transaction: immediate return to reset values. The master must re-assert SS_n before the next transaction is recognised.

Test Plan:
- Write then read: write reg 5 = 0xA5 (cmd 0x2A, 0xA5), then read (cmd 0x28, dummy) → wr_strobe once with addr 5 / data 0xA5; read byte on MISO = 0xA5; loc_rdata(5) = 0xA5.
- FIFO drain: push 0x11, 0x22, 0x33, then read addr 1 (cmd 0x08) with 4 data bytes → MISO 0x11, 0x22, 0x33, 0x00; HIRQ bit 2 drops after the third pop.
- FIFO full: push 9 bytes with FIFO_DEPTH=8 → push_ready=0 after the 8th; the 9th byte is lost; a read returns only the first 8.
- Interrupt: reg26 = 0x01, pulse irq_set = 0x01 → INT_n=0 and the status byte = 0x01. Writing 0x01 to addr 25 clears it and INT_n=1. Set and clear in the same cycle → bit stays 1.
- Abort: SS_n rises after 4 bits of a write data byte → no wr_strobe, register unchanged, MISO_oe=0.
- Reset_n pulsed mid-read → all outputs return to reset values.
